// File: rtl/sseg_mux_display.sv
// Time-multiplexed N-digit common-anode 7-segment driver: double-buffered data, LZ suppression, PWM dimming.
// Outputs registered one cycle behind div_cnt/idx; no backpressure, load is always accepted.
module sseg_mux_display #(
  parameter int N_DIGITS   = 4,
  parameter int DIV_W      = 15,
  parameter int BRIGHT_W   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] d_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  load,
  output logic                  pending,
  output logic                  frame_tick,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            ca,
  output logic                  dp
);

  localparam int   IW  = $clog2(N_DIGITS);
  localparam logic INV = (ACTIVE_LOW == 0);

  logic [DIV_W-1:0]      div_cnt;
  logic [IW-1:0]         idx;
  logic                  slot_end, wrap;

  logic [4*N_DIGITS-1:0] sh_d, act_d;
  logic [N_DIGITS-1:0]   sh_dp, act_dp, sh_blank, act_blank;
  logic                  sh_lz, act_lz;

  logic [N_DIGITS-1:0]   supp;
  logic [3:0]            nib;
  logic [6:0]            glyph;
  logic [BRIGHT_W-1:0]   pw;
  logic                  run, pwm_on, lit;
  logic [N_DIGITS-1:0]   an_lo;
  logic [6:0]            ca_lo;
  logic                  dp_lo;

  assign slot_end = &div_cnt;
  assign wrap     = slot_end && (idx == IW'(N_DIGITS - 1));
  assign pw       = div_cnt[DIV_W-1 -: BRIGHT_W];

  always_comb begin
    supp = '0;
    run  = 1'b1;
    nib  = 4'h0;
    // A digit is a leading zero only if it and everything above it is zero with no dp lit.
    for (int j = N_DIGITS - 1; j >= 1; j--) begin
      run     = run && (act_d[4*j +: 4] == 4'h0) && !act_dp[j];
      supp[j] = act_lz && run;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) nib = act_d[4*i +: 4];
    end

    case (nib)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase

    pwm_on = (pw < brightness) || (&brightness);
    lit    = !act_blank[idx] && !supp[idx] && pwm_on;
    an_lo  = lit ? ~(N_DIGITS'(1) << idx) : '1;
    ca_lo  = lit ? glyph : 7'h7F;
    dp_lo  = lit ? !act_dp[idx] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= '0;
      sh_d       <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      sh_lz      <= 1'b0;
      act_d      <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      act_lz     <= 1'b0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      an         <= {N_DIGITS{~INV}};
      ca         <= {7{~INV}};
      dp         <= ~INV;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (slot_end) idx <= wrap ? '0 : idx + 1'b1;

      // Commit reads the pre-load shadow, so a load on the wrap cycle waits a frame.
      if (wrap && pending) begin
        act_d     <= sh_d;
        act_dp    <= sh_dp;
        act_blank <= sh_blank;
        act_lz    <= sh_lz;
        pending   <= 1'b0;
      end
      if (load) begin
        sh_d     <= d_in;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
        sh_lz    <= lz_en;
        pending  <= 1'b1;
      end

      frame_tick <= wrap;
      an         <= an_lo ^ {N_DIGITS{INV}};
      ca         <= ca_lo ^ {7{INV}};
      dp         <= dp_lo ^ INV;
    end
  end

endmodule

// File: tb/tb_sseg_mux_display.sv
// Directed bench for sseg_mux_display (4 digits, 16-cycle slots, 2-bit brightness, active-low).
module tb_sseg_mux_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in;
  logic [3:0]  dp_in, blank_in;
  logic        lz_en;
  logic [1:0]  brightness;
  logic        load;
  logic        pending, frame_tick;
  logic [3:0]  an;
  logic [6:0]  ca;
  logic        dp;

  int checks   = 0;
  int failures = 0;

  logic [6:0] exp_ca [4];
  logic [3:0] exp_lit, exp_dp;

  sseg_mux_display #(.N_DIGITS(4), .DIV_W(4), .BRIGHT_W(2), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .dp_in(dp_in), .blank_in(blank_in),
    .lz_en(lz_en), .brightness(brightness), .load(load), .pending(pending),
    .frame_tick(frame_tick), .an(an), .ca(ca), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl,
                         input logic lz);
    d_in = d; dp_in = dpv; blank_in = bl; lz_en = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 200);
    if (!frame_tick) check("tick_timeout", {31'd0, frame_tick}, 32'd1);
  endtask

  // Entered on the negedge where frame_tick is high; sample k shows digit (k-1)/16 at pw ((k-1)%16)/4.
  task automatic run_frame(input string tag, input int load_at, input logic [15:0] ld,
                           input logic pend0);
    int s, p;
    logic on, epend, edp;
    logic [3:0] ean;
    logic [6:0] eca;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      load = 1'b0;
      s   = (k - 1) / 16;
      p   = (k - 1) % 16;
      on  = exp_lit[s] && (((p / 4) < int'(brightness)) || brightness == 2'd3);
      ean = on ? ~(4'b0001 << s) : 4'hF;
      eca = on ? exp_ca[s] : 7'h7F;
      edp = on ? !exp_dp[s] : 1'b1;
      if (k == 64)                       epend = (load_at == 63);
      else if (load_at >= 0 && k > load_at) epend = 1'b1;
      else                               epend = pend0;
      check($sformatf("%s_k%0d", tag, k), {19'd0, frame_tick, pending, an, ca, dp},
            {19'd0, (k == 64), epend, ean, eca, edp});
      if (k == load_at) begin
        d_in = ld; dp_in = 4'h0; blank_in = 4'h0; lz_en = 1'b0; load = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; d_in = '0; dp_in = '0; blank_in = '0; lz_en = 1'b0;
    brightness = 2'd0; load = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", {pending, frame_tick, an, ca, dp}, {2'b00, 4'hF, 7'h7F, 1'b1});
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_hold", {pending, frame_tick, an, ca, dp}, {2'b00, 4'hF, 7'h7F, 1'b1});

    // Scan order and slot/frame timing
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    check("pend_rise", {31'd0, pending}, 32'd1);
    brightness = 2'd3;
    wait_tick();
    check("pend_commit", {31'd0, pending}, 32'd0);
    exp_lit = 4'hF; exp_dp = 4'h0;
    exp_ca  = '{7'h0E, 7'h08, 7'h24, 7'h79};
    run_frame("scan", -1, 16'h0, 1'b0);

    brightness = 2'd1;
    run_frame("bright1", -1, 16'h0, 1'b0);
    brightness = 2'd0;
    run_frame("bright0", -1, 16'h0, 1'b0);
    brightness = 2'd3;

    // Leading-zero suppression, then a dp on the top digit stops it
    do_load(16'h0050, 4'h0, 4'h0, 1'b1);
    wait_tick();
    exp_lit = 4'b0011; exp_dp = 4'h0;
    exp_ca  = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    run_frame("lz", -1, 16'h0, 1'b0);
    do_load(16'h0050, 4'b1000, 4'h0, 1'b1);
    wait_tick();
    exp_lit = 4'hF; exp_dp = 4'b1000;
    exp_ca  = '{7'h40, 7'h12, 7'h40, 7'h40};
    run_frame("lz_dp", -1, 16'h0, 1'b0);

    // Double buffer: mid-frame load held until wrap; load on the wrap deferred a frame
    run_frame("hold", 20, 16'h1111, 1'b0);
    exp_lit = 4'hF; exp_dp = 4'h0;
    exp_ca  = '{7'h79, 7'h79, 7'h79, 7'h79};
    run_frame("wrap_load", 63, 16'h12AF, 1'b0);
    run_frame("deferred", -1, 16'h0, 1'b1);
    exp_ca  = '{7'h0E, 7'h08, 7'h24, 7'h79};
    run_frame("late_show", -1, 16'h0, 1'b0);

    // Blanking of a single digit
    do_load(16'h12AF, 4'h0, 4'b0100, 1'b0);
    wait_tick();
    exp_lit = 4'b1011;
    run_frame("blank", -1, 16'h0, 1'b0);

    // Reset during digit 1 with data pending
    do_load(16'h1111, 4'h0, 4'h0, 1'b0);
    repeat (20) @(negedge clk);
    check("pre_rst_digit1", {28'd0, an}, 32'hD);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", {pending, frame_tick, an, ca, dp}, {2'b00, 4'hF, 7'h7F, 1'b1});
    rst = 1'b0;
    wait_tick();
    exp_lit = 4'hF; exp_dp = 4'h0;
    exp_ca  = '{7'h40, 7'h40, 7'h40, 7'h40};
    run_frame("post_rst", -1, 16'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
